fc_argmax: RTL and testbench

Sequential classifier back end that consumes the ten 9-bit popcount scores produced by the binary fully-connected stage and reports the winning digit. Latches all scores on a single-cycle valid pulse, scans them one per cycle, and emits digit index, best-vs-second margin and a low-confidence flag with a one-cycle valid pulse. Sits between the FC layer and the top-level result register/UART reporter.

---
 rtl/fc_argmax_pkg.sv | 16 +
 rtl/fc_argmax_step.sv | 29 ++
 rtl/fc_argmax.sv | 130 +++++++++++++
 tb/tb_fc_argmax.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fc_argmax_pkg.sv
// Shared constants and state encoding for the classifier back end.
// fc_layer and the top level use these as well.
package fc_argmax_pkg;

  localparam int SCORE_W     = 9;
  localparam int NUM_CLASSES = 10;
  localparam int IDX_W       = 4;

  localparam logic [SCORE_W-1:0] MARGIN_MIN = 9'd8;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

endpackage

// File: rtl/fc_argmax_step.sv
// One compare step of the running best/second-best search.
// A strict compare keeps the lowest index on ties, and an equal score lands in second.
module argmax_step
  import fc_argmax_pkg::*;
(
  input  logic [SCORE_W-1:0] s,
  input  logic [IDX_W-1:0]   idx,
  input  logic [SCORE_W-1:0] best,
  input  logic [SCORE_W-1:0] second,
  input  logic [IDX_W-1:0]   best_idx,
  output logic [SCORE_W-1:0] best_nxt,
  output logic [SCORE_W-1:0] second_nxt,
  output logic [IDX_W-1:0]   best_idx_nxt
);

  always_comb begin
    best_nxt     = best;
    second_nxt   = second;
    best_idx_nxt = best_idx;
    if (s > best) begin
      second_nxt   = best;
      best_nxt     = s;
      best_idx_nxt = idx;
    end else if (s > second) begin
      second_nxt = s;
    end
  end

endmodule

// File: rtl/fc_argmax.sv
// Latches ten popcount scores, scans them one per cycle and reports the
// winning digit, the best-vs-second margin and a low-confidence flag.
module fc_argmax
  import fc_argmax_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid_in,
  input  logic [SCORE_W-1:0] score_1,
  input  logic [SCORE_W-1:0] score_2,
  input  logic [SCORE_W-1:0] score_3,
  input  logic [SCORE_W-1:0] score_4,
  input  logic [SCORE_W-1:0] score_5,
  input  logic [SCORE_W-1:0] score_6,
  input  logic [SCORE_W-1:0] score_7,
  input  logic [SCORE_W-1:0] score_8,
  input  logic [SCORE_W-1:0] score_9,
  input  logic [SCORE_W-1:0] score_10,
  output logic [3:0]         digit,
  output logic [SCORE_W-1:0] margin,
  output logic               low_conf,
  output logic               valid_out,
  output logic               busy,
  output logic               overrun
);

  state_t state, state_nxt;

  logic [SCORE_W-1:0] buffer [NUM_CLASSES];
  logic [IDX_W-1:0]   idx;
  logic [SCORE_W-1:0] best;
  logic [SCORE_W-1:0] second;
  logic [IDX_W-1:0]   best_idx;

  logic [SCORE_W-1:0] step_best;
  logic [SCORE_W-1:0] step_second;
  logic [IDX_W-1:0]   step_best_idx;
  logic [SCORE_W-1:0] margin_nxt;

  logic capture;
  logic last_step;

  assign capture    = (state == IDLE) && valid_in;
  assign last_step  = (state == SCAN) && (idx == IDX_W'(NUM_CLASSES - 1));
  assign margin_nxt = step_best - step_second;

  argmax_step u_step (
    .s            (buffer[idx]),
    .idx          (idx),
    .best         (best),
    .second       (second),
    .best_idx     (best_idx),
    .best_nxt     (step_best),
    .second_nxt   (step_second),
    .best_idx_nxt (step_best_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (valid_in)  state_nxt = SCAN;
      SCAN:    if (last_step) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // busy decodes the state register directly, so it stays glitch-free and registered.
  always_comb begin
    busy = (state == SCAN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CLASSES; i++) buffer[i] <= '0;
      idx      <= '0;
      best     <= '0;
      second   <= '0;
      best_idx <= '0;
    end else if (capture) begin
      buffer[0] <= score_1;
      buffer[1] <= score_2;
      buffer[2] <= score_3;
      buffer[3] <= score_4;
      buffer[4] <= score_5;
      buffer[5] <= score_6;
      buffer[6] <= score_7;
      buffer[7] <= score_8;
      buffer[8] <= score_9;
      buffer[9] <= score_10;
      idx       <= '0;
      best      <= '0;
      second    <= '0;
      best_idx  <= '0;
    end else if (state == SCAN) begin
      best     <= step_best;
      second   <= step_second;
      best_idx <= step_best_idx;
      idx      <= idx + IDX_W'(1);
    end
  end

  // Result takes the post-update values of the last compare, so class 9 can still win.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit     <= '0;
      margin    <= '0;
      low_conf  <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (last_step) begin
        digit     <= step_best_idx;
        margin    <= margin_nxt;
        low_conf  <= (margin_nxt < MARGIN_MIN);
        valid_out <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          overrun <= 1'b0;
    else if (valid_in && state == SCAN)  overrun <= 1'b1;
  end

endmodule

// File: tb/tb_fc_argmax.sv
// Directed and randomized checks of fc_argmax with a queue of expected results
// that a monitor pops whenever valid_out is seen.
module tb_fc_argmax;
  import fc_argmax_pkg::*;

  typedef struct {
    logic [3:0]         d;
    logic [SCORE_W-1:0] m;
    logic               lc;
  } exp_t;

  logic               clk;
  logic               rst_n;
  logic               valid_in;
  logic [SCORE_W-1:0] sc [10];
  logic [3:0]         digit;
  logic [SCORE_W-1:0] margin;
  logic               low_conf;
  logic               valid_out;
  logic               busy;
  logic               overrun;

  exp_t exp_q [$];
  int   n_tests = 0;
  int   n_fail  = 0;

  fc_argmax dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .score_1   (sc[0]),
    .score_2   (sc[1]),
    .score_3   (sc[2]),
    .score_4   (sc[3]),
    .score_5   (sc[4]),
    .score_6   (sc[5]),
    .score_7   (sc[6]),
    .score_8   (sc[7]),
    .score_9   (sc[8]),
    .score_10  (sc[9]),
    .digit     (digit),
    .margin    (margin),
    .low_conf  (low_conf),
    .valid_out (valid_out),
    .busy      (busy),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [SCORE_W-1:0] v [10]);
    exp_t r;
    int bi = 0;
    logic [SCORE_W-1:0] sec = '0;
    for (int i = 1; i < 10; i++) if (v[i] > v[bi]) bi = i;
    for (int i = 0; i < 10; i++) if (i != bi && v[i] > sec) sec = v[i];
    r.d  = 4'(bi);
    r.m  = v[bi] - sec;
    r.lc = (r.m < 9'd8);
    return r;
  endfunction

  function automatic exp_t mk(input int d, input int m, input bit lc);
    exp_t r;
    r.d  = 4'(d);
    r.m  = SCORE_W'(m);
    r.lc = lc;
    return r;
  endfunction

  // Monitor: every valid_out pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n && valid_out) begin
      check_output("result_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check_output("digit", 32'(digit), 32'(e.d));
        check_output("margin", 32'(margin), 32'(e.m));
        check_output("low_conf", 32'(low_conf), 32'(e.lc));
      end
    end
  end

  // Drives one capture pulse; returns 1 time unit after the capture edge with inputs scrambled.
  task automatic start_scan(input logic [SCORE_W-1:0] v [10]);
    @(posedge clk);
    #1;
    sc       = v;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    for (int i = 0; i < 10; i++) sc[i] = SCORE_W'($urandom_range(0, 400));
  endtask

  task automatic apply_stimulus(input logic [SCORE_W-1:0] v [10], input exp_t e);
    exp_q.push_back(e);
    start_scan(v);
  endtask

  // Counts edges after capture until valid_out, checking busy along the way.
  task automatic wait_result(input string tag, input int k0);
    int k = k0;
    do begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (!valid_out && k < 10) check_output({tag, "_busy"}, 32'(busy), 32'd1);
    end while (!valid_out && k < 20);
    check_output({tag, "_latency"}, 32'(k), 32'd10);
    check_output({tag, "_busy_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [SCORE_W-1:0] v [10];
    logic [SCORE_W-1:0] w [10];
    int seen;

    rst_n    = 1'b0;
    valid_in = 1'b0;
    for (int i = 0; i < 10; i++) sc[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_digit", 32'(digit), 32'd0);
    check_output("rst_margin", 32'(margin), 32'd0);
    check_output("rst_valid_out", 32'(valid_out), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_overrun", 32'(overrun), 32'd0);
    rst_n = 1'b1;

    v = '{100, 120, 340, 90, 85, 70, 60, 50, 40, 80};
    apply_stimulus(v, mk(2, 220, 0));
    check_output("basic_busy_e0", 32'(busy), 32'd1);
    wait_result("basic", 0);

    v = '{200, 10, 150, 250, 0, 199, 30, 250, 5, 180};
    apply_stimulus(v, mk(3, 0, 1));
    wait_result("tie", 0);

    v = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    apply_stimulus(v, mk(0, 0, 1));
    wait_result("zeros", 0);

    v = '{400, 400, 400, 400, 400, 400, 400, 400, 400, 400};
    apply_stimulus(v, mk(0, 0, 1));
    wait_result("all_max", 0);

    v = '{295, 10, 20, 30, 40, 50, 60, 70, 80, 300};
    apply_stimulus(v, mk(9, 5, 1));
    wait_result("last_class", 0);
    check_output("overrun_clear", 32'(overrun), 32'd0);

    // Second pulse sampled at E4 must be dropped and flag overrun.
    v = '{10, 20, 30, 40, 50, 60, 70, 380, 90, 100};
    apply_stimulus(v, mk(7, 280, 0));
    repeat (3) @(posedge clk);
    #1;
    sc       = '{399, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    check_output("overrun_set", 32'(overrun), 32'd1);
    wait_result("overrun_run", 4);

    // Pulse held across E10 (dropped) and E11 (accepted).
    v = '{5, 6, 7, 8, 9, 10, 11, 12, 13, 50};
    apply_stimulus(v, mk(9, 37, 0));
    repeat (9) @(posedge clk);
    #1;
    sc       = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 399};
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    check_output("e10_valid_out", 32'(valid_out), 32'd1);
    w = '{300, 0, 0, 0, 0, 0, 0, 0, 0, 100};
    sc = w;
    exp_q.push_back(mk(0, 200, 0));
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    check_output("e11_busy", 32'(busy), 32'd1);
    wait_result("e11_run", 0);
    check_output("overrun_sticky", 32'(overrun), 32'd1);

    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 10; i++) v[i] = SCORE_W'($urandom_range(0, 400));
      apply_stimulus(v, model(v));
      wait_result("random", 0);
    end

    // Reset during scan cycle 5 discards the partial result.
    v = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    start_scan(v);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_output("midrst_digit", 32'(digit), 32'd0);
    check_output("midrst_margin", 32'(margin), 32'd0);
    check_output("midrst_low_conf", 32'(low_conf), 32'd0);
    check_output("midrst_busy", 32'(busy), 32'd0);
    check_output("midrst_overrun", 32'(overrun), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (valid_out) seen++;
    end
    check_output("midrst_no_valid", 32'(seen), 32'd0);

    v = '{50, 60, 70, 80, 90, 100, 110, 120, 130, 135};
    apply_stimulus(v, mk(9, 5, 1));
    wait_result("post_rst", 0);

    repeat (2) @(posedge clk);
    check_output("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
